regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for a 32x32 register file: clears the file after reset,
// then grants one of three requesters per cycle in round-robin order.
module regfile_wb_arbiter #(
   parameter logic [31:0] CLEAR_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [4:0]  req0_num,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [4:0]  req1_num,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   input  logic        req2_valid,
   input  logic [4:0]  req2_num,
   input  logic [31:0] req2_data,
   output logic        req2_ready,
   output logic        rf_we,
   output logic [4:0]  rf_w_num,
   output logic [31:0] rf_din,
   output logic        init_done,
   output logic [1:0]  grant_id
);

   // Handshake: a write transfers on any cycle where reqK_valid && reqK_ready.
   // Ready is a function of state, last and the valids only, so a requester
   // must hold valid/num/data stable until it sees ready.
   typedef enum logic {INIT, RUN} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [1:0]  last;

   logic [2:0]  valid_vec;
   logic [1:0]  p0, p1, p2;
   logic [1:0]  sel;
   logic        sel_any;
   logic [2:0]  ready_vec;
   logic [4:0]  sel_num;
   logic [31:0] sel_data;

   // Search order starts one past the last winner, wrapping 2 -> 0.
   always_comb begin
      valid_vec = {req2_valid, req1_valid, req0_valid};
      p0 = (last >= 2'd2) ? 2'd0 : last + 2'd1;
      p1 = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
      p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
      sel     = 2'd0;
      sel_any = 1'b0;
      if (valid_vec[p0]) begin
         sel     = p0;
         sel_any = 1'b1;
      end else if (valid_vec[p1]) begin
         sel     = p1;
         sel_any = 1'b1;
      end else if (valid_vec[p2]) begin
         sel     = p2;
         sel_any = 1'b1;
      end
      ready_vec = 3'b000;
      if (rst_n && state == RUN && sel_any)
         ready_vec = 3'b001 << sel;
   end

   always_comb begin
      sel_num  = req0_num;
      sel_data = req0_data;
      case (sel)
         2'd1: begin
            sel_num  = req1_num;
            sel_data = req1_data;
         end
         2'd2: begin
            sel_num  = req2_num;
            sel_data = req2_data;
         end
         default: begin
            sel_num  = req0_num;
            sel_data = req0_data;
         end
      endcase
   end

   assign req0_ready = ready_vec[0];
   assign req1_ready = ready_vec[1];
   assign req2_ready = ready_vec[2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= INIT;
         cnt       <= 5'd0;
         last      <= 2'd2;
         rf_we     <= 1'b0;
         rf_w_num  <= 5'd0;
         rf_din    <= 32'd0;
         init_done <= 1'b0;
         grant_id  <= 2'b11;
      end else begin
         case (state)
            INIT: begin
               rf_we    <= 1'b1;
               rf_w_num <= cnt;
               rf_din   <= (cnt == 5'd0) ? 32'd0 : CLEAR_VAL;
               grant_id <= 2'b11;
               cnt      <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state     <= RUN;
                  init_done <= 1'b1;
               end
            end
            RUN: begin
               if (sel_any) begin
                  last     <= sel;
                  grant_id <= sel;
                  // Writes to register 0 are consumed but never reach the file.
                  if (sel_num != 5'd0) begin
                     rf_we    <= 1'b1;
                     rf_w_num <= sel_num;
                     rf_din   <= sel_data;
                  end else begin
                     rf_we <= 1'b0;
                  end
               end else begin
                  rf_we    <= 1'b0;
                  grant_id <= 2'b11;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: init sweep, table of RUN-mode
// arbitration vectors, and reset-abort sequences.
module tb_regfile_wb_arbiter;

   localparam logic [31:0] CLR = 32'hA5A5_0001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid, req2_valid;
   logic [4:0]  req0_num, req1_num, req2_num;
   logic [31:0] req0_data, req1_data, req2_data;
   logic        req0_ready, req1_ready, req2_ready;
   logic        rf_we;
   logic [4:0]  rf_w_num;
   logic [31:0] rf_din;
   logic        init_done;
   logic [1:0]  grant_id;

   int checks = 0;
   int passed = 0;

   regfile_wb_arbiter #(.CLEAR_VAL(CLR)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_num(req0_num), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_num(req1_num), .req1_data(req1_data), .req1_ready(req1_ready),
      .req2_valid(req2_valid), .req2_num(req2_num), .req2_data(req2_data), .req2_ready(req2_ready),
      .rf_we(rf_we), .rf_w_num(rf_w_num), .rf_din(rf_din),
      .init_done(init_done), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  v;
      logic [4:0]  n0, n1, n2;
      logic [31:0] d0, d1, d2;
      logic [2:0]  rdy;
      logic        we;
      logic [4:0]  wnum;
      logic [31:0] din;
      logic [1:0]  gid;
      logic        chk_wd;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(logic [2:0] v, logic [4:0] n0, logic [4:0] n1, logic [4:0] n2,
                               logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                               logic [2:0] rdy, logic we, logic [4:0] wnum, logic [31:0] din,
                               logic [1:0] gid, logic chk_wd);
      vec_t r;
      r.v = v; r.n0 = n0; r.n1 = n1; r.n2 = n2;
      r.d0 = d0; r.d1 = d1; r.d2 = d2;
      r.rdy = rdy; r.we = we; r.wnum = wnum; r.din = din; r.gid = gid; r.chk_wd = chk_wd;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " rf_we"}, {31'd0, rf_we}, 32'd0);
      chk({tag, " rf_w_num"}, {27'd0, rf_w_num}, 32'd0);
      chk({tag, " rf_din"}, rf_din, 32'd0);
      chk({tag, " init_done"}, {31'd0, init_done}, 32'd0);
      chk({tag, " grant_id"}, {30'd0, grant_id}, 32'd3);
   endtask

   task automatic run_init(input string tag);
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("%s ready0 c%0d", tag, i), {31'd0, req0_ready}, 32'd0);
         tick();
         chk($sformatf("%s we e%0d", tag, i + 1), {31'd0, rf_we}, 32'd1);
         chk($sformatf("%s wnum e%0d", tag, i + 1), {27'd0, rf_w_num}, i);
         chk($sformatf("%s din e%0d", tag, i + 1), rf_din, (i == 0) ? 32'd0 : CLR);
         chk($sformatf("%s init_done e%0d", tag, i + 1), {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      // Expected values assume last=0 on entry (requester 0 won the first RUN cycle).
      vecs[0]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5'd3, 32'hCAFE_0003, 2'd3, 1);
      vecs[1]  = mk(3'b100, 0, 0, 0, 0, 0, 32'h1234, 3'b100, 0, 5'd3, 32'hCAFE_0003, 2'd2, 0);
      vecs[2]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 3'b001, 1, 5'd5, 32'h1111_0000, 2'd0, 1);
      vecs[3]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 3'b010, 1, 5'd6, 32'h2222_0001, 2'd1, 1);
      vecs[4]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 3'b100, 1, 5'd7, 32'h3333_0002, 2'd2, 1);
      vecs[5]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 3'b001, 1, 5'd5, 32'h1111_0000, 2'd0, 1);
      vecs[6]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 3'b010, 1, 5'd6, 32'h2222_0001, 2'd1, 1);
      vecs[7]  = mk(3'b111, 5, 6, 7, 32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 3'b100, 1, 5'd7, 32'h3333_0002, 2'd2, 1);
      vecs[8]  = mk(3'b010, 0, 9, 0, 0, 32'hDEAD_BEEF, 0, 3'b010, 1, 5'd9, 32'hDEAD_BEEF, 2'd1, 1);
      vecs[9]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5'd9, 32'hDEAD_BEEF, 2'd3, 1);
      vecs[10] = mk(3'b101, 4, 0, 12, 32'h0000_0044, 0, 32'h0000_00CC, 3'b100, 1, 5'd12, 32'h0000_00CC, 2'd2, 1);
      vecs[11] = mk(3'b011, 4, 1, 0, 32'h0000_0044, 32'h0000_0011, 0, 3'b001, 1, 5'd4, 32'h0000_0044, 2'd0, 1);
      vecs[12] = mk(3'b110, 0, 1, 31, 0, 32'h0000_0011, 32'hFFFF_FFFF, 3'b010, 1, 5'd1, 32'h0000_0011, 2'd1, 1);

      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; req2_valid = 0;
      req0_num = 0; req1_num = 0; req2_num = 0;
      req0_data = 0; req1_data = 0; req2_data = 0;
      tick();
      tick();
      chk_reset_outputs("reset");
      chk("reset readies", {29'd0, req2_ready, req1_ready, req0_ready}, 32'd0);

      // Release with requester 0 already waiting; it must be held off for all of INIT.
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_num = 5'd3; req0_data = 32'hCAFE_0003;
      run_init("init");
      chk("first run readies", {29'd0, req2_ready, req1_ready, req0_ready}, 32'd1);
      tick();
      chk("first run we", {31'd0, rf_we}, 32'd1);
      chk("first run wnum", {27'd0, rf_w_num}, 32'd3);
      chk("first run din", rf_din, 32'hCAFE_0003);
      chk("first run gid", {30'd0, grant_id}, 32'd0);

      for (int k = 0; k < 13; k++) begin
         {req2_valid, req1_valid, req0_valid} = vecs[k].v;
         req0_num = vecs[k].n0; req1_num = vecs[k].n1; req2_num = vecs[k].n2;
         req0_data = vecs[k].d0; req1_data = vecs[k].d1; req2_data = vecs[k].d2;
         #1;
         chk($sformatf("vec%0d ready", k), {29'd0, req2_ready, req1_ready, req0_ready}, {29'd0, vecs[k].rdy});
         tick();
         chk($sformatf("vec%0d we", k), {31'd0, rf_we}, {31'd0, vecs[k].we});
         chk($sformatf("vec%0d gid", k), {30'd0, grant_id}, {30'd0, vecs[k].gid});
         if (vecs[k].chk_wd) begin
            chk($sformatf("vec%0d wnum", k), {27'd0, rf_w_num}, {27'd0, vecs[k].wnum});
            chk($sformatf("vec%0d din", k), rf_din, vecs[k].din);
         end
      end

      // Reset during RUN gates ready immediately and clears outputs on the edge.
      req0_valid = 1'b1; req0_num = 5'd2; req1_valid = 0; req2_valid = 0;
      rst_n = 1'b0;
      #1;
      chk("run reset ready0", {31'd0, req0_ready}, 32'd0);
      tick();
      chk_reset_outputs("run reset");

      // Abort INIT at cnt==17 and confirm a full restart.
      req0_valid = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) tick();
      chk("mid init wnum", {27'd0, rf_w_num}, 32'd16);
      rst_n = 1'b0;
      tick();
      chk_reset_outputs("mid init reset");
      rst_n = 1'b1;
      run_init("reinit");
      tick();
      chk("post init idle we", {31'd0, rf_we}, 32'd0);
      chk("post init idle gid", {30'd0, grant_id}, 32'd3);
      chk("post init idle wnum", {27'd0, rf_w_num}, 32'd31);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
